adder_bist: RTL



---
 rtl/adder_bist_pkg.sv | 20 ++
 rtl/adder_bist_delay.sv | 40 ++++
 rtl/adder_bist.sv | 139 +++++++++++++
 3 files changed

// File: rtl/adder_bist_pkg.sv
// adder_bist_pkg: shared state encoding and vector-space helper for the adder BIST.
// Rev 1.0
`default_nettype none

package adder_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   function automatic int unsigned num_vectors(input int unsigned width);
      return 32'd1 << (2 * width);
   endfunction

endpackage

`default_nettype wire

// File: rtl/adder_bist_delay.sv
// adder_bist_delay: DEPTH-stage shift register carrying {valid, data} alongside the adder.
// Rev 1.0
`default_nettype none

module adder_bist_delay #(
   parameter int DW    = 4,
   parameter int DEPTH = 2
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          valid_i,
   input  logic [DW-1:0] data_i,
   output logic          valid_o,
   output logic [DW-1:0] data_o
);

   logic [DEPTH-1:0] vld_q;
   logic [DW-1:0]    data_q [DEPTH];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         vld_q     <= {vld_q[DEPTH-2:0], valid_i};
         data_q[0] <= data_i;
         for (int i = 1; i < DEPTH; i++) begin
            data_q[i] <= data_q[i-1];
         end
      end
   end

   assign valid_o = vld_q[DEPTH-1];
   assign data_o  = data_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/adder_bist.sv
// adder_bist: exhaustive operand sweep of a registered adder with on-chip golden compare.
// Rev 1.0
`default_nettype none

module adder_bist
   import adder_bist_pkg::*;
#(
   parameter int WIDTH   = 2,
   parameter int LATENCY = 1
) (
   input  logic               Clk,
   input  logic               Rst_n,
   input  logic               Start,
   output logic [WIDTH-1:0]   A,
   output logic [WIDTH-1:0]   B,
   input  logic [WIDTH-1:0]   Sum_reg,
   input  logic               Carry_reg,
   output logic               Busy,
   output logic               Done,
   output logic               Pass,
   output logic [2*WIDTH:0]   Pass_count,
   output logic               Fail_seen,
   output logic [2*WIDTH-1:0] First_fail
);

   localparam int            VW       = 2 * WIDTH;
   localparam logic [VW:0]   NUM_VEC  = (VW+1)'(num_vectors(WIDTH));
   localparam logic [VW:0]   CNT_ONE  = 1;
   localparam logic [VW-1:0] VEC_ONE  = 1;
   localparam logic [VW-1:0] LAST_VEC = '1;

   state_e          state_q, state_d;
   logic [VW-1:0]   vec_q, vec_d;
   logic            issue_d;
   logic [VW:0]     pass_cnt_q, pass_cnt_d;
   logic            fail_q, fail_d;
   logic [VW-1:0]   ffail_q, ffail_d;

   logic            pipe_vld;
   logic [VW-1:0]   pipe_vec;
   logic [WIDTH-1:0] pipe_a, pipe_b;
   logic [WIDTH:0]  expected;
   logic            mismatch;

   // The pipe is fed with the vector being loaded, so stage 0 mirrors {A,B}.
   adder_bist_delay #(
      .DW    (VW),
      .DEPTH (LATENCY + 1)
   ) u_delay (
      .clk_i   (Clk),
      .rst_ni  (Rst_n),
      .valid_i (issue_d),
      .data_i  (vec_d),
      .valid_o (pipe_vld),
      .data_o  (pipe_vec)
   );

   assign pipe_a = pipe_vec[VW-1:WIDTH];
   assign pipe_b = pipe_vec[WIDTH-1:0];

   always_comb begin
      state_d    = state_q;
      vec_d      = vec_q;
      issue_d    = 1'b0;
      pass_cnt_d = pass_cnt_q;
      fail_d     = fail_q;
      ffail_d    = ffail_q;
      expected   = {1'b0, pipe_a} + {1'b0, pipe_b};
      mismatch   = ({Carry_reg, Sum_reg} !== expected);

      if (pipe_vld) begin
         if (mismatch) begin
            fail_d = 1'b1;
            if (!fail_q) begin
               ffail_d = pipe_vec;
            end
         end else begin
            pass_cnt_d = pass_cnt_q + CNT_ONE;
         end
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (Start) begin
               state_d    = ST_RUN;
               vec_d      = '0;
               issue_d    = 1'b1;
               pass_cnt_d = '0;
               fail_d     = 1'b0;
               ffail_d    = '0;
            end
         end
         ST_RUN: begin
            if (vec_q == LAST_VEC) begin
               state_d = ST_DRAIN;
               vec_d   = '0;
            end else begin
               vec_d   = vec_q + VEC_ONE;
               issue_d = 1'b1;
            end
         end
         ST_DRAIN: begin
            // The last vector at the pipe output is compared on this edge.
            if (pipe_vld && (pipe_vec == LAST_VEC)) begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q    <= ST_IDLE;
         vec_q      <= '0;
         pass_cnt_q <= '0;
         fail_q     <= 1'b0;
         ffail_q    <= '0;
      end else begin
         state_q    <= state_d;
         vec_q      <= vec_d;
         pass_cnt_q <= pass_cnt_d;
         fail_q     <= fail_d;
         ffail_q    <= ffail_d;
      end
   end

   assign A          = vec_q[VW-1:WIDTH];
   assign B          = vec_q[WIDTH-1:0];
   assign Busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign Done       = (state_q == ST_DONE);
   assign Pass       = Done && (pass_cnt_q == NUM_VEC);
   assign Pass_count = pass_cnt_q;
   assign Fail_seen  = fail_q;
   assign First_fail = ffail_q;

endmodule

`default_nettype wire
